// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module   : multicycle_control_pkg
// Brief    : State, opcode, ALUOp, source-mux and trap-cause encodings shared
//            by the multi-cycle RV64 subset control path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Must match the ALU-control decoder's interpretation of ALUOp.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_BUS     = 2'b10;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Unified-memory request/ready handshake between control and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
    modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

`default_nettype wire

// File: rtl/multicycle_control_wait.sv
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Counts stalled memory cycles; flags when the timeout is reached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam logic [7:0] C_LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_cnt <= 8'd0;
        end else if (enable && (r_cnt != C_LIMIT)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign expired = (r_cnt == C_LIMIT);
endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Main sequencer of the multi-cycle RV64 subset core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [6:0]       opcode,
    input  wire logic             zero,
    multicycle_control_if.master  mem,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic                  reg_write,
    output logic                  result_src,
    output logic                  halted,
    output logic [1:0]            trap_cause,
    output logic [CNT_W-1:0]      instret,
    output logic [3:0]            state_dbg
);
    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_trap_cause;
    logic [CNT_W-1:0] r_instret;
    logic             w_expired;
    logic             w_retire;
    logic             w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_reg_write;

    // Any state change clears the counter, so every memory-state entry starts at zero.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_next != r_state),
        .enable  (is_mem_state(r_state) && !mem.mem_ready),
        .expired (w_expired)
    );

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:  if (mem.mem_ready) w_next = S_DECODE;
                      else if (w_expired) w_next = S_TRAP;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXEC_R;
                    OP_IMM:            w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem.mem_ready) w_next = S_MEMWB;
                      else if (w_expired) w_next = S_TRAP;
            S_MEMWB:  begin w_next = S_FETCH; w_retire = 1'b1; end
            S_MEMWR:  if (mem.mem_ready) begin
                          w_next   = S_FETCH;
                          w_retire = 1'b1;
                      end else if (w_expired) begin
                          w_next = S_TRAP;
                      end
            S_EXEC_R: w_next = S_ALUWB;
            S_EXEC_I: w_next = S_ALUWB;
            S_ALUWB:  begin w_next = S_FETCH; w_retire = 1'b1; end
            S_BRANCH: begin w_next = S_FETCH; w_retire = 1'b1; end
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_instret    <= '0;
            r_trap_cause <= TRAP_NONE;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
            if ((w_next == S_TRAP) && (r_state != S_TRAP))
                r_trap_cause <= (r_state == S_DECODE) ? TRAP_ILLEGAL : TRAP_BUS;
        end
    end

    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        mem.i_or_d  = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        pc_src      = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALUOP_ADD;
        w_reg_write = 1'b0;
        result_src  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                w_ir_write = mem.mem_ready;
                w_pc_write = mem.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                w_mem_req  = 1'b1;
                mem.i_or_d = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                result_src  = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req  = 1'b1;
                w_mem_we   = 1'b1;
                mem.i_or_d = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                pc_src     = 1'b1;
                w_pc_write = zero;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so an in-flight store cannot complete during reset.
    assign mem.mem_req = w_mem_req   && rst_n;
    assign mem.mem_we  = w_mem_we    && rst_n;
    assign ir_write    = w_ir_write  && rst_n;
    assign pc_write    = w_pc_write  && rst_n;
    assign reg_write   = w_reg_write && rst_n;

    assign halted     = (r_state == S_TRAP);
    assign trap_cause = r_trap_cause;
    assign instret    = r_instret;
    assign state_dbg  = r_state;
endmodule

`default_nettype wire
